mfb_frame_rr_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that merges INPUTS single-region MFB streams into one MFB stream.
- Once an input is granted at SOF, it keeps the output until its frame's EOF, so frames are never interleaved.
- Sits in front of the MFB reconfigurator or any single-consumer MFB datapath shared by several producers.
- Output is registered: one cycle latency, full throughput under TX_DST_RDY backpressure.

---
 rtl/mfb_frame_rr_arbiter.sv | 90 +++++++++
 tb/tb_mfb_frame_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfb_frame_rr_arbiter.sv
// mfb_frame_rr_arbiter: frame-granular round-robin merge of several single-region MFB streams
module mfb_frame_rr_arbiter #(
  parameter int INPUTS      = 2,
  parameter int REGION_SIZE = 8,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 8,
  parameter int META_WIDTH  = 8,
  localparam int DW   = REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH,
  localparam int SW   = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int EW   = (REGION_SIZE * BLOCK_SIZE > 1) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1,
  localparam int SELW = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [INPUTS*DW-1:0]         RX_DATA,
  input  logic [INPUTS*META_WIDTH-1:0] RX_META,
  input  logic [INPUTS*SW-1:0]         RX_SOF_POS,
  input  logic [INPUTS*EW-1:0]         RX_EOF_POS,
  input  logic [INPUTS-1:0]            RX_SOF,
  input  logic [INPUTS-1:0]            RX_EOF,
  input  logic [INPUTS-1:0]            RX_SRC_RDY,
  output logic [INPUTS-1:0]            RX_DST_RDY,
  output logic [DW-1:0]                TX_DATA,
  output logic [META_WIDTH-1:0]        TX_META,
  output logic [SW-1:0]                TX_SOF_POS,
  output logic [EW-1:0]                TX_EOF_POS,
  output logic                         TX_SOF,
  output logic                         TX_EOF,
  output logic                         TX_SRC_RDY,
  input  logic                         TX_DST_RDY,
  output logic [SELW-1:0]              TX_SEL
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]      r_state;
  logic [SELW-1:0] r_sel, r_rr, w_rr_idx, w_j, w_idx;
  logic            w_rr_vld, w_out_en, w_gnt_vld, w_xfer, w_sof, w_eof, w_drop, w_open_next;
  // Scan from the far end so the requester closest to r_rr is the last one written.
  always_comb begin
    w_rr_idx = '0;
    w_rr_vld = 1'b0;
    w_j      = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      w_j = SELW'((int'(r_rr) + k) % INPUTS);
      if (RX_SRC_RDY[w_j]) begin
        w_rr_idx = w_j;
        w_rr_vld = 1'b1;
      end
    end
  end
  assign w_out_en    = !TX_SRC_RDY || TX_DST_RDY;
  assign w_idx       = (r_state == LOCKED) ? r_sel : w_rr_idx;
  assign w_gnt_vld   = w_out_en && ((r_state == LOCKED) || w_rr_vld);
  assign RX_DST_RDY  = w_gnt_vld ? ({{(INPUTS-1){1'b0}}, 1'b1} << w_idx) : '0;
  assign w_xfer      = w_gnt_vld && RX_SRC_RDY[w_idx];
  assign w_sof       = RX_SOF[w_idx];
  assign w_eof       = RX_EOF[w_idx];
  assign w_drop      = (r_state == IDLE) && !w_sof;
  // An EOF+SOF word keeps whatever lock state was already in force.
  assign w_open_next = w_sof ? (!w_eof || r_state == LOCKED) : (!w_eof && r_state == LOCKED);
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TX_SRC_RDY <= 1'b0;
      TX_SOF     <= 1'b0;
      TX_EOF     <= 1'b0;
      TX_SEL     <= '0;
      r_state    <= IDLE;
      r_sel      <= '0;
      r_rr       <= '0;
    end else if (w_xfer && !w_drop) begin
      TX_SRC_RDY <= 1'b1;
      TX_SOF     <= w_sof;
      TX_EOF     <= w_eof;
      TX_SEL     <= w_idx;
      r_state    <= w_open_next ? LOCKED : IDLE;
      r_sel      <= w_idx;
      if (!w_open_next) r_rr <= (w_idx == SELW'(INPUTS - 1)) ? '0 : w_idx + 1'b1;
    end else if (w_out_en) begin
      TX_SRC_RDY <= 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_xfer && !w_drop) begin
      TX_DATA    <= RX_DATA[w_idx*DW +: DW];
      TX_META    <= RX_META[w_idx*META_WIDTH +: META_WIDTH];
      TX_SOF_POS <= RX_SOF_POS[w_idx*SW +: SW];
      TX_EOF_POS <= RX_EOF_POS[w_idx*EW +: EW];
    end
  end
endmodule

// File: tb/tb_mfb_frame_rr_arbiter.sv
// tb_mfb_frame_rr_arbiter: randomized and directed bench with a frame-level arbitration model
module tb_mfb_frame_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 512;
  localparam int MW = 8;
  localparam int SW = 3;
  localparam int EW = 6;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] meta;
    logic [SW-1:0] sp;
    logic [EW-1:0] ep;
    logic          sof;
    logic          eof;
  } word_t;
  typedef struct packed {
    logic [1:0] sel;
    word_t      w;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*DW-1:0] rx_data;
  logic [N*MW-1:0] rx_meta;
  logic [N*SW-1:0] rx_sp;
  logic [N*EW-1:0] rx_ep;
  logic [N-1:0]    rx_sof, rx_eof, rx_src_rdy, rx_dst_rdy;
  logic [DW-1:0]   tx_data;
  logic [MW-1:0]   tx_meta;
  logic [SW-1:0]   tx_sp;
  logic [EW-1:0]   tx_ep;
  logic            tx_sof, tx_eof, tx_src_rdy, tx_dst_rdy;
  logic [1:0]      tx_sel;
  word_t src_q[N][$];
  exp_t  sb[$];
  int    sel_log[$];
  int    cyc_log[$];
  int    n_chk = 0, n_fail = 0;
  int    p_valid = 100, p_dst = 100;
  bit    stall_en = 1'b0;
  bit    rst_req = 1'b0;
  int    m_owner = -1, m_rr = 0;
  bit    m_txv = 1'b0;
  int    cyc = 0;
  mfb_frame_rr_arbiter #(.INPUTS(N), .REGION_SIZE(8), .BLOCK_SIZE(8), .ITEM_WIDTH(8), .META_WIDTH(MW)) dut (
    .CLK(clk), .RESET(rst),
    .RX_DATA(rx_data), .RX_META(rx_meta), .RX_SOF_POS(rx_sp), .RX_EOF_POS(rx_ep),
    .RX_SOF(rx_sof), .RX_EOF(rx_eof), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy),
    .TX_DATA(tx_data), .TX_META(tx_meta), .TX_SOF_POS(tx_sp), .TX_EOF_POS(tx_ep),
    .TX_SOF(tx_sof), .TX_EOF(tx_eof), .TX_SRC_RDY(tx_src_rdy), .TX_DST_RDY(tx_dst_rdy),
    .TX_SEL(tx_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic word_t mk(bit s, bit e);
    word_t w;
    for (int k = 0; k < DW / 32; k++) w.data[k*32 +: 32] = $urandom;
    w.meta = MW'($urandom);
    w.sp   = SW'($urandom);
    w.ep   = EW'($urandom);
    w.sof  = s;
    w.eof  = e;
    return w;
  endfunction
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  // Reference: who owns the output and which input is next in line, from the frame rules.
  task automatic step();
    bit [N-1:0] req;
    bit         dst, out_en;
    int         g;
    word_t      w;
    exp_t       e;
    for (int i = 0; i < N; i++) begin
      req[i] = (src_q[i].size() > 0) && (($urandom % 100) < p_valid);
      if (src_q[i].size() > 0) begin
        w = src_q[i][0];
        rx_data[i*DW +: DW] = w.data;
        rx_meta[i*MW +: MW] = w.meta;
        rx_sp[i*SW +: SW]   = w.sp;
        rx_ep[i*EW +: EW]   = w.ep;
        rx_sof[i]           = w.sof;
        rx_eof[i]           = w.eof;
      end
    end
    rx_src_rdy = req;
    dst = (($urandom % 100) < p_dst) && !(stall_en && (cyc % 50) >= 45);
    tx_dst_rdy = dst;
    out_en = !m_txv || dst;
    g = -1;
    if (out_en) begin
      if (m_owner >= 0) g = m_owner;
      else for (int k = 0; k < N && g < 0; k++) if (req[(m_rr + k) % N]) g = (m_rr + k) % N;
    end
    #1;
    chk("rx_dst_rdy", 64'(rx_dst_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g >= 0 && req[g]) begin
      w = src_q[g].pop_front();
      if (m_owner < 0 && !w.sof) m_txv = 1'b0;
      else begin
        e.sel = 2'(g);
        e.w   = w;
        sb.push_back(e);
        m_txv = 1'b1;
        if (w.sof && !w.eof) m_owner = g;
        else if (w.eof && !(w.sof && m_owner >= 0)) begin
          m_owner = -1;
          m_rr    = (g + 1) % N;
        end
      end
    end else if (out_en) m_txv = 1'b0;
  endtask
  initial begin
    rx_data = '0; rx_meta = '0; rx_sp = '0; rx_ep = '0;
    rx_sof = '0; rx_eof = '0; rx_src_rdy = '0; tx_dst_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_req) begin
        rst_req = 1'b0;
        rst = 1'b1;
        rx_src_rdy = '0;
        tx_dst_rdy = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        sb.delete();
        m_owner = -1;
        m_rr = 0;
        m_txv = 1'b0;
      end else begin
        rst = 1'b0;
        chk("tx_src_rdy", 64'(tx_src_rdy), 64'(m_txv));
        step();
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tx_src_rdy && tx_dst_rdy) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got word from sel %0d expected no word (cycle %0d)", tx_sel, cyc);
        end else begin
          e = sb.pop_front();
          if (tx_sel !== e.sel || tx_data !== e.w.data || tx_meta !== e.w.meta || tx_sp !== e.w.sp ||
              tx_ep !== e.w.ep || tx_sof !== e.w.sof || tx_eof !== e.w.eof) begin
            n_fail++;
            $display("FAIL tx_word: got sel=%0d sof=%0b eof=%0b sp=%0d ep=%0d meta=%0h data=%0h expected sel=%0d sof=%0b eof=%0b sp=%0d ep=%0d meta=%0h data=%0h",
                     tx_sel, tx_sof, tx_eof, tx_sp, tx_ep, tx_meta, tx_data[63:0],
                     e.sel, e.w.sof, e.w.eof, e.w.sp, e.w.ep, e.w.meta, e.w.data[63:0]);
          end
        end
        sel_log.push_back(int'(tx_sel));
        cyc_log.push_back(cyc);
      end
    end
  end
  task automatic drain(string name, int budget);
    int c = 0;
    while (c < budget && (sb.size() > 0 || pending())) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    chk({name, "_timeout"}, 64'(c >= budget), 64'd0);
  endtask
  task automatic chk_log(string name, input int e[$]);
    chk({name, "_len"}, 64'(sel_log.size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < sel_log.size(); k++) chk(name, 64'(sel_log[k]), 64'(e[k]));
  endtask
  task automatic gen(int i, int frames);
    bit open = 1'b0;
    int f = 0;
    while (f < frames || open) begin
      int r;
      r = int'($urandom % 100);
      if (!open) begin
        if (r < 5) src_q[i].push_back(mk(1'b0, r[0]));
        else if (r < 45) begin src_q[i].push_back(mk(1'b1, 1'b1)); f++; end
        else begin src_q[i].push_back(mk(1'b1, 1'b0)); open = 1'b1; end
      end else begin
        if (r < 50) src_q[i].push_back(mk(1'b0, 1'b0));
        else if (r < 85) begin src_q[i].push_back(mk(1'b0, 1'b1)); open = 1'b0; f++; end
        else begin src_q[i].push_back(mk(1'b1, 1'b1)); f++; end
      end
    end
  endtask
  initial begin
    int    e[$];
    int    c;
    word_t w;
    wait (rst === 1'b0);
    @(posedge clk);
    #3;
    chk("reset_tx_src_rdy", 64'(tx_src_rdy), 64'd0);
    chk("reset_rx_dst_rdy", 64'(rx_dst_rdy), 64'd0);
    chk("reset_tx_sel", 64'(tx_sel), 64'd0);
    sel_log.delete();
    cyc_log.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) src_q[i].push_back(mk(1'b1, 1'b1));
    drain("rr", 200);
    e = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_log("rr_seq", e);
    chk("rr_throughput", 64'(cyc_log.size() >= 8 ? cyc_log[7] - cyc_log[0] : -1), 64'd7);
    sel_log.delete();
    src_q[1].push_back(mk(1'b1, 1'b0));
    w = mk(1'b1, 1'b1);
    w.ep = 6'd10;
    w.sp = 3'd2;
    src_q[1].push_back(w);
    src_q[1].push_back(mk(1'b0, 1'b1));
    drain("chain", 200);
    e = '{1, 1, 1};
    chk_log("chain_seq", e);
    sel_log.delete();
    src_q[2].push_back(mk(1'b1, 1'b0));
    src_q[2].push_back(mk(1'b0, 1'b0));
    src_q[2].push_back(mk(1'b0, 1'b1));
    src_q[0].push_back(mk(1'b1, 1'b1));
    drain("lock", 200);
    e = '{2, 2, 2, 0};
    chk_log("lock_seq", e);
    src_q[3].push_back(mk(1'b1, 1'b0));
    repeat (4) src_q[3].push_back(mk(1'b0, 1'b0));
    src_q[3].push_back(mk(1'b0, 1'b1));
    c = 0;
    while (src_q[3].size() > 3 && c < 50) begin
      @(posedge clk);
      c++;
    end
    chk("lock3_timeout", 64'(c >= 50), 64'd0);
    rst_req = 1'b1;
    wait (rst === 1'b1);
    @(posedge clk);
    #3;
    chk("mid_reset_tx_src_rdy", 64'(tx_src_rdy), 64'd0);
    sel_log.delete();
    for (int i = 0; i < 3; i++) src_q[i].push_back(mk(1'b1, 1'b1));
    drain("post_reset", 200);
    e = '{0, 1, 2};
    chk_log("post_reset_seq", e);
    p_valid = 70;
    p_dst = 75;
    stall_en = 1'b1;
    for (int i = 0; i < N; i++) gen(i, 250);
    drain("random", 40000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
